// File: rtl/div_rs_if.sv
// CDB packet type plus the dispatch/issue bundle connecting the divide
// reservation station to the dispatch stage and the divider.
package div_rs_pkg;
  localparam int CDB_ROB_W = 4;

  typedef struct packed {
    logic [CDB_ROB_W-1:0] dest_ROB_entry;
    logic [31:0]          result;
    logic                 load_step1;
  } CDB_packet_t;
endpackage

// Handshakes: a transfer happens on a posedge where valid and ready are both
// high. disp_ready depends only on registered RS state. issue_valid depends
// only on registered RS state, and fu_ready may be sampled combinationally.
interface div_rs_if #(
  parameter int ROB_W = 4
);
  logic             disp_valid;
  logic             disp_ready;
  logic [ROB_W-1:0] disp_rob_entry;
  logic [3:0]       disp_aluop;
  logic             disp_src1_rdy;
  logic             disp_src2_rdy;
  logic [31:0]      disp_src1_val;
  logic [31:0]      disp_src2_val;
  logic [ROB_W-1:0] disp_src1_tag;
  logic [ROB_W-1:0] disp_src2_tag;

  logic             fu_ready;
  logic             issue_valid;
  logic [ROB_W-1:0] issue_rob_entry;
  logic [3:0]       issue_aluop;
  logic [31:0]      issue_dividend;
  logic [31:0]      issue_divisor;

  modport master (
    output disp_valid, disp_rob_entry, disp_aluop,
    output disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
    output disp_src1_tag, disp_src2_tag, fu_ready,
    input  disp_ready, issue_valid, issue_rob_entry, issue_aluop,
    input  issue_dividend, issue_divisor
  );

  modport slave (
    input  disp_valid, disp_rob_entry, disp_aluop,
    input  disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
    input  disp_src1_tag, disp_src2_tag, fu_ready,
    output disp_ready, issue_valid, issue_rob_entry, issue_aluop,
    output issue_dividend, issue_divisor
  );
endinterface

// File: rtl/div_rs.sv
// Reservation station for the integer divider: compacting age-ordered queue
// with CDB operand capture and oldest-ready issue.
module div_rs
  import div_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         cdb_valid,
  input  CDB_packet_t                  cdb,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  div_rs_if.slave                      io
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob;
    logic [3:0]       aluop;
    logic             s1_rdy;
    logic [31:0]      s1_val;
    logic [ROB_W-1:0] s1_tag;
    logic             s2_rdy;
    logic [31:0]      s2_val;
    logic [ROB_W-1:0] s2_tag;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  entry_t [DEPTH-1:0] cap;
  entry_t [DEPTH-1:0] shifted;
  entry_t             new_ent;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   sel;
  logic               any_rdy;
  logic               cdb_hit;
  logic               issue_fire;
  logic               disp_fire;

  assign cdb_hit    = cdb_valid & ~cdb.load_step1;
  assign io.disp_ready = (count_q < CNT_W'(DEPTH));
  assign disp_fire  = io.disp_valid & io.disp_ready;
  assign issue_fire = any_rdy & io.fu_ready;
  assign count      = count_q;

  // Oldest ready entry wins: scan downward so the lowest index is kept.
  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel     = IDX_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign io.issue_valid     = any_rdy;
  assign io.issue_rob_entry = ent_q[sel].rob;
  assign io.issue_aluop     = ent_q[sel].aluop;
  assign io.issue_dividend  = ent_q[sel].s1_val;
  assign io.issue_divisor   = ent_q[sel].s2_val;

  // Incoming op, with same-cycle CDB bypass for operands still pending.
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.rob    = io.disp_rob_entry;
    new_ent.aluop  = io.disp_aluop;
    new_ent.s1_rdy = io.disp_src1_rdy;
    new_ent.s1_val = io.disp_src1_val;
    new_ent.s1_tag = io.disp_src1_tag;
    new_ent.s2_rdy = io.disp_src2_rdy;
    new_ent.s2_val = io.disp_src2_val;
    new_ent.s2_tag = io.disp_src2_tag;
    if (cdb_hit && !io.disp_src1_rdy && io.disp_src1_tag == cdb.dest_ROB_entry) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = cdb.result;
    end
    if (cdb_hit && !io.disp_src2_rdy && io.disp_src2_tag == cdb.dest_ROB_entry) begin
      new_ent.s2_rdy = 1'b1;
      new_ent.s2_val = cdb.result;
    end
  end

  // Capture first, then compact over the issued slot, then append.
  always_comb begin
    cap = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit && cap[i].valid && !cap[i].s1_rdy && cap[i].s1_tag == cdb.dest_ROB_entry) begin
        cap[i].s1_rdy = 1'b1;
        cap[i].s1_val = cdb.result;
      end
      if (cdb_hit && cap[i].valid && !cap[i].s2_rdy && cap[i].s2_tag == cdb.dest_ROB_entry) begin
        cap[i].s2_rdy = 1'b1;
        cap[i].s2_val = cdb.result;
      end
    end

    shifted = cap;
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel) shifted[i] = cap[i+1];
      end
      shifted[DEPTH-1] = '0;
    end

    wr_idx = count_q - CNT_W'(issue_fire);
    ent_d  = shifted;
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) ent_d[i] = new_ent;
      end
    end
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

    if (flush) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_div_rs.sv
// Directed bench for div_rs: issue order checked against an expected queue,
// plus point checks on count, readiness, flush and reset.
module tb_div_rs;
  import div_rs_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        cdb_valid;
  CDB_packet_t cdb;
  logic [2:0]  count;

  div_rs_if #(.ROB_W(4)) bus ();

  div_rs #(.DEPTH(4), .ROB_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb       (cdb),
    .count     (count),
    .io        (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [71:0] exp_q[$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pk(input logic [3:0] rob, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    return {rob, op, a, b};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic drive_disp(input logic [3:0] rob, input logic [3:0] op,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    bus.disp_valid     = 1'b1;
    bus.disp_rob_entry = rob;
    bus.disp_aluop     = op;
    bus.disp_src1_rdy  = r1;
    bus.disp_src1_val  = v1;
    bus.disp_src1_tag  = t1;
    bus.disp_src2_rdy  = r2;
    bus.disp_src2_val  = v2;
    bus.disp_src2_tag  = t2;
  endtask

  task automatic drive_cdb(input logic [3:0] dest, input logic [31:0] res, input logic ls);
    cdb_valid          = 1'b1;
    cdb.dest_ROB_entry = dest;
    cdb.result         = res;
    cdb.load_step1     = ls;
  endtask

  // scoreboard: every completed handshake must match the head of exp_q
  always @(negedge clk) begin
    if (reset_n && bus.issue_valid && bus.fu_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_with_empty_queue", 72'(exp_q.size()), 72'd1);
      end else begin
        check("issue", {bus.issue_rob_entry, bus.issue_aluop, bus.issue_dividend, bus.issue_divisor},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.fu_ready = 1'b0;
    cdb = '0;
    drive_disp(4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
    idle();
    #3;
    check("rst_count", 72'(count), 72'd0);
    check("rst_disp_ready", 72'(bus.disp_ready), 72'd1);
    check("rst_issue_valid", 72'(bus.issue_valid), 72'd0);
    check("rst_issue_data", {bus.issue_rob_entry, bus.issue_aluop, bus.issue_dividend, bus.issue_divisor}, 72'd0);
    #9 reset_n = 1'b1;
    tick();

    // ready dispatch: issuable the next cycle
    bus.fu_ready = 1'b1;
    drive_disp(4'd3, 4'd1, 1'b1, 32'd100, 4'd0, 1'b1, 32'd3, 4'd0);
    exp_q.push_back(pk(4'd3, 4'd1, 32'd100, 32'd3));
    tick();
    idle();
    check("t1_issue_valid", 72'(bus.issue_valid), 72'd1);
    check("t1_issue_rob", 72'(bus.issue_rob_entry), 72'd3);
    check("t1_count", 72'(count), 72'd1);
    tick();
    check("t1_count_after", 72'(count), 72'd0);

    // CDB wakeup, load_step1 packets ignored
    drive_disp(4'd5, 4'd0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd7, 4'd0);
    tick();
    idle();
    check("t2_pending", 72'(bus.issue_valid), 72'd0);
    drive_cdb(4'd9, 32'd99, 1'b1);
    tick();
    idle();
    check("t2_load_step1_no_wake", 72'(bus.issue_valid), 72'd0);
    drive_cdb(4'd9, 32'd56, 1'b0);
    exp_q.push_back(pk(4'd5, 4'd0, 32'd56, 32'd7));
    check("t2_not_yet", 72'(bus.issue_valid), 72'd0);
    tick();
    idle();
    check("t2_woken", 72'(bus.issue_valid), 72'd1);
    check("t2_dividend", 72'(bus.issue_dividend), 72'd56);
    tick();

    // both sources woken by one broadcast
    drive_disp(4'd12, 4'd0, 1'b0, 32'd0, 4'd2, 1'b0, 32'd0, 4'd2);
    tick();
    idle();
    drive_cdb(4'd2, 32'd15, 1'b0);
    exp_q.push_back(pk(4'd12, 4'd0, 32'd15, 32'd15));
    tick();
    idle();
    check("t2b_both_woken", 72'(bus.issue_valid), 72'd1);
    tick();
    check("t2b_count", 72'(count), 72'd0);

    // age order and full backpressure
    bus.fu_ready = 1'b0;
    drive_disp(4'd1, 4'd1, 1'b0, 32'd0, 4'd10, 1'b1, 32'd8, 4'd0);
    tick();
    drive_disp(4'd2, 4'd1, 1'b1, 32'd20, 4'd0, 1'b1, 32'd4, 4'd0);
    tick();
    drive_disp(4'd3, 4'd0, 1'b1, 32'd90, 4'd0, 1'b0, 32'd0, 4'd10);
    tick();
    drive_disp(4'd4, 4'd0, 1'b1, 32'd30, 4'd0, 1'b1, 32'd5, 4'd0);
    tick();
    drive_disp(4'd7, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    check("t3_full_count", 72'(count), 72'd4);
    check("t3_full_disp_ready", 72'(bus.disp_ready), 72'd0);
    check("t3_head_sel", 72'(bus.issue_rob_entry), 72'd2);
    tick();
    idle();
    check("t3_fifth_ignored", 72'(count), 72'd4);
    bus.fu_ready = 1'b1;
    exp_q.push_back(pk(4'd2, 4'd1, 32'd20, 32'd4));
    exp_q.push_back(pk(4'd4, 4'd0, 32'd30, 32'd5));
    tick();
    check("t3_disp_ready_back", 72'(bus.disp_ready), 72'd1);
    check("t3_count3", 72'(count), 72'd3);
    check("t3_next_sel", 72'(bus.issue_rob_entry), 72'd4);
    tick();
    check("t3_none_ready", 72'(bus.issue_valid), 72'd0);
    drive_cdb(4'd10, 32'd40, 1'b0);
    exp_q.push_back(pk(4'd1, 4'd1, 32'd40, 32'd8));
    exp_q.push_back(pk(4'd3, 4'd0, 32'd90, 32'd40));
    tick();
    idle();
    check("t3_oldest_first", 72'(bus.issue_rob_entry), 72'd1);
    tick();
    check("t3_then_rob3", 72'(bus.issue_rob_entry), 72'd3);
    tick();
    check("t3_empty", 72'(count), 72'd0);

    // dispatch + capture into survivor + bypass + issue in one cycle
    bus.fu_ready = 1'b0;
    drive_disp(4'd8, 4'd1, 1'b1, 32'd50, 4'd0, 1'b1, 32'd2, 4'd0);
    tick();
    drive_disp(4'd13, 4'd0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0);
    tick();
    bus.fu_ready = 1'b1;
    drive_disp(4'd9, 4'd1, 1'b1, 32'd70, 4'd0, 1'b0, 32'd0, 4'd6);
    drive_cdb(4'd6, 32'd10, 1'b0);
    exp_q.push_back(pk(4'd8, 4'd1, 32'd50, 32'd2));
    exp_q.push_back(pk(4'd13, 4'd0, 32'd10, 32'd3));
    exp_q.push_back(pk(4'd9, 4'd1, 32'd70, 32'd10));
    tick();
    idle();
    check("t5_count_same", 72'(count), 72'd2);
    check("t5_survivor_sel", 72'(bus.issue_rob_entry), 72'd13);
    tick();
    check("t5_bypass_divisor", 72'(bus.issue_divisor), 72'd10);
    tick();
    check("t5_empty", 72'(count), 72'd0);

    // flush beats a same-cycle dispatch
    bus.fu_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_disp(4'(i), 4'd1, 1'b1, 32'(i * 11), 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
    end
    idle();
    check("t6_count3", 72'(count), 72'd3);
    flush = 1'b1;
    drive_disp(4'd14, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
    check("t6_valid_in_flush", 72'(bus.issue_valid), 72'd1);
    tick();
    idle();
    check("t6_flush_count", 72'(count), 72'd0);
    check("t6_flush_issue", 72'(bus.issue_valid), 72'd0);

    // asynchronous reset mid-cycle
    drive_disp(4'd6, 4'd0, 1'b1, 32'd9, 4'd0, 1'b1, 32'd3, 4'd0);
    tick();
    tick();
    idle();
    check("t7_pre_count", 72'(count), 72'd2);
    #3 reset_n = 1'b0;
    #1;
    check("t7_rst_count", 72'(count), 72'd0);
    check("t7_rst_disp_ready", 72'(bus.disp_ready), 72'd1);
    check("t7_rst_issue", 72'(bus.issue_valid), 72'd0);
    #1 reset_n = 1'b1;
    tick();
    check("t7_after_count", 72'(count), 72'd0);

    check("sb_drained", 72'(exp_q.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
